spi_slave_os: RTL

SPI_SLAVE_OS -- requirements
Module: spi_slave_os

---
 rtl/spi_slave_os_pkg.sv | 17 +
 rtl/spi_os_sync.sv | 33 +++
 rtl/spi_slave_os.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/spi_slave_os_pkg.sv
// Shared FSM encoding, defaults and counter sizing for the oversampled SPI slave.
package spi_slave_os_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int M_DEF    = 16;
    localparam int SYNC_DEF = 2;

    function automatic int cnt_w(input int m);
        return $clog2(m + 2);
    endfunction

endpackage

// File: rtl/spi_os_sync.sv
// SYNC-deep synchronizer with a history flop producing rise/fall pulses.
module spi_os_sync
    import spi_slave_os_pkg::*;
#(
    parameter int   SYNC = SYNC_DEF,
    parameter logic RST  = 1'b0
) (
    input  logic clk_i,
    input  logic clr_n_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC-1:0] sync_q;
    logic            hist_q;

    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            sync_q <= {SYNC{RST}};
            hist_q <= RST;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], d_i};
            hist_q <= sync_q[SYNC-1];
        end
    end

    assign q_o    = sync_q[SYNC-1];
    assign rise_o = q_o & ~hist_q;
    assign fall_o = ~q_o & hist_q;

endmodule

// File: rtl/spi_slave_os.sv
// Oversampling SPI slave (CPOL=0, CPHA=0, MSB first) clocked by clk.
// Define SPI_SLAVE_OS_FRAME_ERR_EN to reject frames whose bit count is not M.
module spi_slave_os
    import spi_slave_os_pkg::*;
#(
    parameter int M    = M_DEF,
    parameter int SYNC = SYNC_DEF
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         sclk,
    input  logic         mosi,
    input  logic         load,
    input  logic [M-1:0] DI,
    output logic         miso,
    output logic [M-1:0] DO,
    output logic         done,
    output logic         busy,
    output logic         err
);

    localparam int          CW     = cnt_w(M);
    localparam logic [CW-1:0] CNT_M  = CW'(M);
    localparam logic [CW-1:0] CNT_MX = CW'(M + 1);
    localparam logic [1:0]  SYNC_L = 2'(SYNC);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic load_lvl, load_rise, load_fall;
    logic unused_sync;

    spi_os_sync #(.SYNC(SYNC), .RST(1'b0)) u_sclk (
        .clk_i(clk), .clr_n_i(clr_n), .d_i(sclk),
        .q_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_os_sync #(.SYNC(SYNC), .RST(1'b0)) u_mosi (
        .clk_i(clk), .clr_n_i(clr_n), .d_i(mosi),
        .q_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );
    spi_os_sync #(.SYNC(SYNC), .RST(1'b1)) u_load (
        .clk_i(clk), .clr_n_i(clr_n), .d_i(load),
        .q_o(load_lvl), .rise_o(load_rise), .fall_o(load_fall)
    );

    assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

    state_t        state_q, state_d;
    logic [M-1:0]  tx_q, tx_d, rx_q, rx_d, do_q, do_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          miso_q, miso_d, done_q, done_d, err_q, err_d;
    logic          armed_q, armed_d;
    logic [1:0]    flush_q, flush_d;
    logic          start;

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        do_d    = do_q;
        cnt_d   = cnt_q;
        miso_d  = miso_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        // A frame may only open once load has been seen high after reset.
        flush_d = (flush_q == SYNC_L) ? flush_q : flush_q + 2'd1;
        armed_d = armed_q | ((flush_q == SYNC_L) & load_lvl);
        start   = armed_q & load_fall;

        unique case (state_q)
            IDLE: begin
                if (start) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (load_rise) begin
                    state_d = DONE;
                end else if (sclk_rise) begin
                    rx_d = {rx_q[M-2:0], mosi_lvl};
                    if (cnt_q != CNT_MX) cnt_d = cnt_q + 1'b1;
                end else if (sclk_fall) begin
                    tx_d   = {tx_q[M-2:0], 1'b0};
                    miso_d = tx_q[M-2];
                end
            end
            DONE: begin
                state_d = start ? ACTIVE : IDLE;
`ifdef SPI_SLAVE_OS_FRAME_ERR_EN
                if (cnt_q == CNT_M) begin
                    do_d   = rx_q;
                    done_d = 1'b1;
                end else begin
                    err_d  = 1'b1;
                end
`else
                do_d   = rx_q;
                done_d = 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase

        if (start && state_q != ACTIVE) begin
            tx_d   = DI;
            miso_d = DI[M-1];
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            do_q    <= '0;
            cnt_q   <= '0;
            miso_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            armed_q <= 1'b0;
            flush_q <= 2'd0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            do_q    <= do_d;
            cnt_q   <= cnt_d;
            miso_q  <= miso_d;
            done_q  <= done_d;
            err_q   <= err_d;
            armed_q <= armed_d;
            flush_q <= flush_d;
        end
    end

    assign miso = miso_q;
    assign DO   = do_q;
    assign done = done_q;
    assign err  = err_q;
    assign busy = (state_q == ACTIVE);

endmodule
